// File: rtl/tune_arbiter_if.sv
// UART byte stream in, tuning word and status strobes out of tune_arbiter.
interface tune_arbiter_if #(
  parameter int PHASE_W = 27
) ();
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic [PHASE_W-1:0] phase_inc;
  logic               phase_inc_valid;
  logic               frame_err;

  modport master (
    output rx_data, rx_valid,
    input  phase_inc, phase_inc_valid, frame_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output phase_inc, phase_inc_valid, frame_err
  );
endinterface

// File: rtl/tune_arbiter.sv
// Owns the AM detector tuning word: merges debounced dial steps and UART SET
// frames into a clamped phase increment with a one-cycle write strobe.
module tune_arbiter #(
  parameter int                 PHASE_W       = 27,
  parameter logic [PHASE_W-1:0] DEFAULT_PHASE = PHASE_W'(8_388_608),
  parameter int                 STEP_INC      = 8389,
  parameter logic [PHASE_W-1:0] PHASE_MIN     = PHASE_W'(838_861),
  parameter logic [PHASE_W-1:0] PHASE_MAX     = PHASE_W'(67_108_863),
  parameter int                 DEBOUNCE      = 1024,
  parameter int                 FRAME_TIMEOUT = 1_280_000
) (
  input logic           aclk,
  input logic           reset,
  input logic           fq_ck,
  input logic           fq_dt,
  tune_arbiter_if.slave bus
);
  localparam int              DBW      = $clog2(DEBOUNCE + 1);
  localparam int              GW       = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [DBW-1:0]  DB_LAST  = DBW'(DEBOUNCE - 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'(FRAME_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_B3, S_B2, S_B1, S_B0} pstate_t;

  function automatic logic [PHASE_W-1:0] sat_up(input logic [PHASE_W-1:0] cur);
    logic [PHASE_W:0] sum;
    sum = {1'b0, cur} + (PHASE_W+1)'(STEP_INC);
    return (sum > {1'b0, PHASE_MAX}) ? PHASE_MAX : sum[PHASE_W-1:0];
  endfunction

  function automatic logic [PHASE_W-1:0] sat_dn(input logic [PHASE_W-1:0] cur);
    logic signed [PHASE_W:0] diff;
    diff = $signed({1'b0, cur}) - $signed((PHASE_W+1)'(STEP_INC));
    return (diff < $signed({1'b0, PHASE_MIN})) ? PHASE_MIN : diff[PHASE_W-1:0];
  endfunction

  function automatic logic [PHASE_W-1:0] clamp_set(input logic [PHASE_W-1:0] w);
    if (w < PHASE_MIN) return PHASE_MIN;
    if (w > PHASE_MAX) return PHASE_MAX;
    return w;
  endfunction

  logic           ck_s1_q, ck_s2_q, dt_s1_q, dt_s2_q;
  logic           ck_db_q, dt_db_q, ck_prev_q, evt_q, evt_dn_q;
  logic [DBW-1:0] ck_cnt_q, dt_cnt_q;

  // Dial: synchronizer -> per-pin debounce -> registered rising-edge event
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      ck_s1_q   <= 1'b0;
      ck_s2_q   <= 1'b0;
      dt_s1_q   <= 1'b0;
      dt_s2_q   <= 1'b0;
      ck_db_q   <= 1'b0;
      dt_db_q   <= 1'b0;
      ck_cnt_q  <= '0;
      dt_cnt_q  <= '0;
      ck_prev_q <= 1'b0;
      evt_q     <= 1'b0;
      evt_dn_q  <= 1'b0;
    end else begin
      ck_s1_q <= fq_ck;
      ck_s2_q <= ck_s1_q;
      dt_s1_q <= fq_dt;
      dt_s2_q <= dt_s1_q;
      if (ck_s2_q == ck_db_q) ck_cnt_q <= '0;
      else if (ck_cnt_q == DB_LAST) begin
        ck_db_q  <= ck_s2_q;
        ck_cnt_q <= '0;
      end else ck_cnt_q <= ck_cnt_q + 1'b1;
      if (dt_s2_q == dt_db_q) dt_cnt_q <= '0;
      else if (dt_cnt_q == DB_LAST) begin
        dt_db_q  <= dt_s2_q;
        dt_cnt_q <= '0;
      end else dt_cnt_q <= dt_cnt_q + 1'b1;
      ck_prev_q <= ck_db_q;
      evt_q     <= ck_db_q & ~ck_prev_q;
      evt_dn_q  <= dt_db_q;
    end
  end

  pstate_t              state_q, state_d;
  logic [PHASE_W-9:0]   word_q, word_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 ferr_q, ferr_d;
  logic                 set_req;
  logic [PHASE_W-1:0]   set_word;

  // Only the low PHASE_W bits of the frame are kept; older bytes shift out the top.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    gap_d    = '0;
    ferr_d   = 1'b0;
    set_req  = 1'b0;
    set_word = {word_q, bus.rx_data};
    if (state_q != S_IDLE) gap_d = bus.rx_valid ? '0 : gap_q + 1'b1;
    case (state_q)
      S_IDLE: if (bus.rx_valid && bus.rx_data == 8'hA5) state_d = S_B3;
      S_B3, S_B2, S_B1: if (bus.rx_valid) begin
        word_d  = {word_q[PHASE_W-17:0], bus.rx_data};
        state_d = (state_q == S_B3) ? S_B2 : (state_q == S_B2) ? S_B1 : S_B0;
      end
      S_B0: if (bus.rx_valid) begin
        state_d = S_IDLE;
        set_req = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && !bus.rx_valid && gap_q == GAP_LAST) begin
      state_d = S_IDLE;
      ferr_d  = 1'b1;
    end
  end

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               pvld_q, pvld_d, ann_q, ann_d, pend_q, pend_d, pend_dn_q, pend_dn_d;
  logic               step_dn;

  // Announce and SET take the write port; a colliding dial step waits one slot.
  always_comb begin
    phase_d   = phase_q;
    pvld_d    = 1'b0;
    ann_d     = ann_q;
    pend_d    = pend_q;
    pend_dn_d = pend_dn_q;
    step_dn   = 1'b0;
    if (ann_q || set_req) begin
      phase_d = ann_q ? DEFAULT_PHASE : clamp_set(set_word);
      pvld_d  = 1'b1;
      ann_d   = 1'b0;
      if (evt_q) begin
        pend_d    = 1'b1;
        pend_dn_d = evt_dn_q;
      end
    end else if (pend_q || evt_q) begin
      step_dn   = pend_q ? pend_dn_q : evt_dn_q;
      phase_d   = step_dn ? sat_dn(phase_q) : sat_up(phase_q);
      pvld_d    = 1'b1;
      pend_d    = pend_q & evt_q;
      pend_dn_d = evt_dn_q;
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      gap_q     <= '0;
      ferr_q    <= 1'b0;
      phase_q   <= DEFAULT_PHASE;
      pvld_q    <= 1'b0;
      ann_q     <= 1'b1;
      pend_q    <= 1'b0;
      pend_dn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      gap_q     <= gap_d;
      ferr_q    <= ferr_d;
      phase_q   <= phase_d;
      pvld_q    <= pvld_d;
      ann_q     <= ann_d;
      pend_q    <= pend_d;
      pend_dn_q <= pend_dn_d;
    end
  end

  assign bus.phase_inc       = phase_q;
  assign bus.phase_inc_valid = pvld_q;
  assign bus.frame_err       = ferr_q;
endmodule

// File: doc/tune_arbiter.md
# tune_arbiter

Owns the AM detector's tuning word: it converts frequency-dial rotation and UART tuning commands into a registered `phase_inc` with a one-cycle `phase_inc_valid` strobe. It sits in the `fast_clk` (128 MHz) domain between the UI front end (dial pins, UART receiver byte stream) and the `am_detector` phase input. It arbitrates between the two requesters and enforces a legal tuning range. After every reset it announces the default tuning so the detector is always configured.

## Interface

Parameters:
- `PHASE_W`, 27: tuning word width.
- `DEFAULT_PHASE`, 27'd8_388_608: value after reset (1 MHz at 16 MHz sample rate).
- `STEP_INC`, 8389: phase increment per dial detent (≈1 kHz).
- `PHASE_MIN`, 27'd838_861: lower clamp (≈100 kHz).
- `PHASE_MAX`, 27'd67_108_863: upper clamp (≈8 MHz, just under Nyquist).
- `DEBOUNCE`, 1024: number of cycles a dial level must stay stable before it is accepted.
- `FRAME_TIMEOUT`, 1_280_000: maximum inter-byte gap in cycles (10 ms).

Ports:
- `aclk`, input, 1: system clock (`fast_clk`).
- `reset`, input, 1: asynchronous, active-high.
- `fq_ck`, input, 1: raw dial clock pin, asynchronous.
- `fq_dt`, input, 1: raw dial data pin, asynchronous.
- `rx_data`, input, 8: received UART byte.
- `rx_valid`, input, 1: one-cycle strobe that qualifies `rx_data`.
- `phase_inc`, output, PHASE_W: current tuning word (registered).
- `phase_inc_valid`, output, 1: one-cycle strobe; asserted on every cycle `phase_inc` is (re)written.
- `frame_err`, output, 1: one-cycle strobe when a frame is aborted by timeout.

## Operation

- Reset (asynchronous) values:
  - `phase_inc` = `DEFAULT_PHASE`.
  - `phase_inc_valid` = 0, `frame_err` = 0.
  - Parser in IDLE, debounce counters 0, pending flag 0, announce flag 1.
- Announce: on the first clock edge after reset deasserts, `phase_inc_valid` pulses once with `DEFAULT_PHASE`.
- Dial path:
  - `fq_ck` and `fq_dt` each pass through a 2-flop synchronizer.
  - Each synchronized signal has its own debounce counter. The counter resets on any difference from the current debounced level. When it reaches `DEBOUNCE`, the debounced level takes the new value.
  - A debounced `fq_ck` rising edge creates a dial event. If debounced `fq_dt` = 0, the event is UP (+`STEP_INC`); if 1, it is DOWN (−`STEP_INC`).
  - Falling edges produce no event.
- UART parser FSM: IDLE → B3 → B2 → B1 → B0 → IDLE.
  - In IDLE, byte 0xA5 moves to B3. Any other byte is ignored.
  - B3..B0 each capture one byte of a 32-bit big-endian word; bits [31:PHASE_W] are discarded.
  - The `rx_valid` that delivers byte B0 completes the frame; the parser returns to IDLE and issues a SET request.
  - A 0xA5 received in B3..B0 is treated as data, not as a resync.
  - The gap timer counts cycles in B3..B0 and clears on each `rx_valid`. When it reaches `FRAME_TIMEOUT`, the parser returns to IDLE and pulses `frame_err`; the partial frame is discarded.
- Arithmetic and clamping:
  - UP: new = min(phase_inc + STEP_INC, PHASE_MAX), computed at PHASE_W+1 bits so it never wraps.
  - DOWN: new = max(phase_inc − STEP_INC, PHASE_MIN), computed signed so it never underflows.
  - SET: new = clamp(word, PHASE_MIN, PHASE_MAX).
  - Every applied event pulses `phase_inc_valid`, including when saturation leaves the value unchanged.
- Arbitration:
  - Priority order: announce > SET > dial.
  - A dial event that collides with SET or announce is latched in a 1-deep pending flag and applied on the next free cycle, relative to the value just written.
  - Events are never lost: the dial produces at most one event per DEBOUNCE cycles, so the pending flag cannot overflow.

## Timing

- SET: `phase_inc`/`phase_inc_valid` update on the edge after the cycle in which the final byte's `rx_valid` is high (1-cycle latency).
- Dial: from a clean `fq_ck` rising transition, `phase_inc` updates exactly DEBOUNCE+4 cycles later:
  - 2 cycles of synchronizer.
  - DEBOUNCE cycles to debounce.
  - 1 cycle for the edge register.
  - 1 cycle to apply.
- A deferred dial event adds 1 cycle.
- `fq_dt` is sampled at its debounced value in the same cycle the debounced `fq_ck` edge is detected.
- Reset mid-frame or mid-debounce returns everything to the reset state. No partial-frame commit and no dial event may follow, only the announce pulse.
- `phase_inc` holds steady between strobes. The consumer in `sample_clk` may sample it on the strobe via its own CDC; this block provides no handshake back.

## Test plan

- Reset release → exactly one `phase_inc_valid` pulse on the first edge with `phase_inc` = 8_388_608, then silence for 10,000 cycles.
- UART bytes A5 00 80 00 00 → `phase_inc` = 8_388_608 one cycle after the last `rx_valid`. Bytes A5 FF FF FF FF → 67_108_863 (clamped). Bytes A5 00 00 00 01 → 838_861.
- Dial rising edge with dt = 0, 5 times, each level held 2×DEBOUNCE → `phase_inc` = 8_388_608 + 5×8389 = 8_430_553, each update DEBOUNCE+4 cycles after its edge. With dt = 1 from 838_861 → stays 838_861 but still pulses valid.
- Glitch on `fq_ck` of DEBOUNCE−1 cycles → no event, no strobe.
- Byte A5 plus two data bytes, then idle for FRAME_TIMEOUT → `frame_err` pulse, parser back in IDLE. A following full frame is accepted normally.
- Dial UP event and UART frame completion in the same cycle → SET value written first, then SET+8389 on the next cycle: two strobes on consecutive cycles.
